// File: rtl/mapper_001.sv
// rtl/mapper_001.sv - MMC1-class mapper: serial-loaded bank registers driving PRG/CHR banking and mirroring.
module mapper_001 #(
    parameter int PRG_ROM_DEPTH      = 18,
    parameter int CHR_ROM_DEPTH      = 17,
    parameter int PRG_RAM_DEPTH      = 13,
    parameter int IGNORE_CONSECUTIVE = 1
) (
    input  logic                     clk_cpu,
    input  logic                     rst_n,
    input  logic [14:0]              cpu_addr,
    input  logic [7:0]               cpu_data_i,
    input  logic [13:0]              ppu_addr,
    input  logic                     cpu_rw,
    input  logic                     romsel,
    input  logic                     mirrorv,
    input  logic                     chr_ram,
    input  logic                     prg_ram,
    input  logic [PRG_ROM_DEPTH-1:0] prg_mask,
    input  logic [CHR_ROM_DEPTH-1:0] chr_mask,
    input  logic [PRG_RAM_DEPTH-1:0] prgram_mask,
    output logic [PRG_ROM_DEPTH-1:0] prg_addr,
    output logic [CHR_ROM_DEPTH-1:0] chr_addr,
    output logic [PRG_RAM_DEPTH-1:0] prgram_addr,
    output logic                     prg_cs,
    output logic                     chr_cs,
    output logic                     prgram_cs,
    output logic [7:0]               mapper_reg_o,
    output logic                     ciram_ce,
    output logic                     ciram_a10,
    output logic                     irq
);

    logic [4:0] shift_q;
    logic [4:0] control_q;
    logic [4:0] chr0_q;
    logic [4:0] chr1_q;
    logic [4:0] prg_q;
    logic       last_wr_q;

    logic       wr;
    logic       accept;
    logic [4:0] load_val;
    logic [3:0] prg_bank;
    logic [4:0] chr_bank;

    assign wr       = romsel & ~cpu_rw;
    assign accept   = wr & ~((IGNORE_CONSECUTIVE != 0) & last_wr_q);
    assign load_val = {cpu_data_i[0], shift_q[4:1]};

    // shift_q carries a sentinel in bit 4; when it reaches bit 0 the current write is the fifth.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= 5'b10000;
            control_q <= 5'h0C;
            chr0_q    <= 5'h00;
            chr1_q    <= 5'h00;
            prg_q     <= 5'h00;
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= wr;
            if (accept) begin
                if (cpu_data_i[7]) begin
                    shift_q   <= 5'b10000;
                    control_q <= control_q | 5'h0C;
                end else if (!shift_q[0]) begin
                    shift_q <= load_val;
                end else begin
                    shift_q <= 5'b10000;
                    case (cpu_addr[14:13])
                        2'd0:    control_q <= load_val;
                        2'd1:    chr0_q    <= load_val;
                        2'd2:    chr1_q    <= load_val;
                        default: prg_q     <= load_val;
                    endcase
                end
            end
        end
    end

    always_comb begin
        prg_bank = {prg_q[3:1], cpu_addr[14]};
        case (control_q[3:2])
            2'b10:   prg_bank = cpu_addr[14] ? prg_q[3:0] : 4'h0;
            2'b11:   prg_bank = cpu_addr[14] ? 4'hF : prg_q[3:0];
            default: prg_bank = {prg_q[3:1], cpu_addr[14]};
        endcase
    end

    always_comb begin
        if (control_q[4]) begin
            chr_bank = ppu_addr[12] ? chr1_q : chr0_q;
        end else begin
            chr_bank = {chr0_q[4:1], ppu_addr[12]};
        end
    end

    always_comb begin
        case (control_q[1:0])
            2'd0:    ciram_a10 = 1'b0;
            2'd1:    ciram_a10 = 1'b1;
            2'd2:    ciram_a10 = ppu_addr[10];
            default: ciram_a10 = ppu_addr[11];
        endcase
    end

    assign prg_addr     = prg_mask & PRG_ROM_DEPTH'({prg_bank, cpu_addr[13:0]});
    assign chr_addr     = chr_mask & CHR_ROM_DEPTH'({chr_bank, ppu_addr[11:0]});
    assign prgram_addr  = prgram_mask & cpu_addr[PRG_RAM_DEPTH-1:0];
    assign prg_cs       = romsel;
    assign chr_cs       = ~ppu_addr[13];
    assign prgram_cs    = prg_ram & ~prg_q[4] & ~romsel & (cpu_addr[14:13] == 2'b11);
    assign mapper_reg_o = {3'b000, control_q};
    assign ciram_ce     = ppu_addr[13];
    assign irq          = 1'b0;

    // Header mirroring and CHR-RAM flags do not affect this mapping.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, mirrorv, chr_ram, cpu_data_i[6:1]};

endmodule

// File: tb/tb_mapper_001.sv
// tb/tb_mapper_001.sv - self-checking bench for mapper_001 (IGNORE_CONSECUTIVE 1 and 0 instances).
module tb_mapper_001;

    logic        clk_cpu = 1'b0;
    logic        rst_n;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_i;
    logic [13:0] ppu_addr;
    logic        cpu_rw, romsel, mirrorv, chr_ram, prg_ram;
    logic [17:0] prg_mask;
    logic [16:0] chr_mask;
    logic [12:0] prgram_mask;

    logic [17:0] prg_addr_a, prg_addr_b;
    logic [16:0] chr_addr_a, chr_addr_b;
    logic [12:0] prgram_addr_a, prgram_addr_b;
    logic        prg_cs_a, chr_cs_a, prgram_cs_a, ciram_ce_a, ciram_a10_a, irq_a;
    logic        prg_cs_b, chr_cs_b, prgram_cs_b, ciram_ce_b, ciram_a10_b, irq_b;
    logic [7:0]  mapper_reg_a, mapper_reg_b;
    logic [61:0] out_a, out_b;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk_cpu = ~clk_cpu;

    mapper_001 #(.IGNORE_CONSECUTIVE(1)) dut_a (
        .clk_cpu(clk_cpu), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
        .ppu_addr(ppu_addr), .cpu_rw(cpu_rw), .romsel(romsel), .mirrorv(mirrorv),
        .chr_ram(chr_ram), .prg_ram(prg_ram), .prg_mask(prg_mask), .chr_mask(chr_mask),
        .prgram_mask(prgram_mask), .prg_addr(prg_addr_a), .chr_addr(chr_addr_a),
        .prgram_addr(prgram_addr_a), .prg_cs(prg_cs_a), .chr_cs(chr_cs_a),
        .prgram_cs(prgram_cs_a), .mapper_reg_o(mapper_reg_a), .ciram_ce(ciram_ce_a),
        .ciram_a10(ciram_a10_a), .irq(irq_a)
    );

    mapper_001 #(.IGNORE_CONSECUTIVE(0)) dut_b (
        .clk_cpu(clk_cpu), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
        .ppu_addr(ppu_addr), .cpu_rw(cpu_rw), .romsel(romsel), .mirrorv(mirrorv),
        .chr_ram(chr_ram), .prg_ram(prg_ram), .prg_mask(prg_mask), .chr_mask(chr_mask),
        .prgram_mask(prgram_mask), .prg_addr(prg_addr_b), .chr_addr(chr_addr_b),
        .prgram_addr(prgram_addr_b), .prg_cs(prg_cs_b), .chr_cs(chr_cs_b),
        .prgram_cs(prgram_cs_b), .mapper_reg_o(mapper_reg_b), .ciram_ce(ciram_ce_b),
        .ciram_a10(ciram_a10_b), .irq(irq_b)
    );

    assign out_a = {prg_addr_a, chr_addr_a, prgram_addr_a, prg_cs_a, chr_cs_a, prgram_cs_a,
                    mapper_reg_a, ciram_ce_a, ciram_a10_a, irq_a};
    assign out_b = {prg_addr_b, chr_addr_b, prgram_addr_b, prg_cs_b, chr_cs_b, prgram_cs_b,
                    mapper_reg_b, ciram_ce_b, ciram_a10_b, irq_b};

    // Model: index 0 ignores consecutive writes, index 1 does not.
    logic [4:0] m_ctrl [2];
    logic [4:0] m_chr0 [2];
    logic [4:0] m_chr1 [2];
    logic [4:0] m_prg  [2];
    logic [4:0] m_acc  [2];
    int         m_cnt  [2];
    bit         m_last [2];
    bit         m_ic   [2] = '{1'b1, 1'b0};

    always @(posedge clk_cpu or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_ctrl[i] = 5'h0C; m_chr0[i] = 0; m_chr1[i] = 0; m_prg[i] = 0;
                m_acc[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
            end else begin
                bit w;
                w = romsel && !cpu_rw;
                if (w && !(m_ic[i] && m_last[i])) begin
                    if (cpu_data_i[7]) begin
                        m_acc[i] = 0; m_cnt[i] = 0;
                        m_ctrl[i] = m_ctrl[i] | 5'h0C;
                    end else begin
                        m_acc[i][m_cnt[i]] = cpu_data_i[0];
                        m_cnt[i]++;
                        if (m_cnt[i] == 5) begin
                            case (int'(cpu_addr) / 8192)
                                0: m_ctrl[i] = m_acc[i];
                                1: m_chr0[i] = m_acc[i];
                                2: m_chr1[i] = m_acc[i];
                                default: m_prg[i] = m_acc[i];
                            endcase
                            m_acc[i] = 0; m_cnt[i] = 0;
                        end
                    end
                end
                m_last[i] = w;
            end
        end
    end

    function automatic logic [61:0] model_out(int i);
        int b, c, pa, ca;
        logic a10, ram_cs;
        if (m_ctrl[i][3:2] < 2)       b = (int'(m_prg[i][3:0]) & 14) + int'(cpu_addr[14]);
        else if (m_ctrl[i][3:2] == 2) b = cpu_addr[14] ? int'(m_prg[i][3:0]) : 0;
        else                          b = cpu_addr[14] ? 15 : int'(m_prg[i][3:0]);
        pa = (b * 16384 + int'(cpu_addr[13:0])) & int'(prg_mask);
        if (!m_ctrl[i][4]) c = (int'(m_chr0[i]) & 30) + int'(ppu_addr[12]);
        else               c = ppu_addr[12] ? int'(m_chr1[i]) : int'(m_chr0[i]);
        ca = (c * 4096 + int'(ppu_addr[11:0])) & int'(chr_mask);
        case (m_ctrl[i][1:0])
            0: a10 = 0;
            1: a10 = 1;
            2: a10 = ppu_addr[10];
            default: a10 = ppu_addr[11];
        endcase
        ram_cs = prg_ram && !m_prg[i][4] && !romsel && (cpu_addr >= 15'h6000);
        return {pa[17:0], ca[16:0], cpu_addr[12:0] & prgram_mask, romsel, !ppu_addr[13],
                ram_cs, 3'b000, m_ctrl[i], ppu_addr[13], a10, 1'b0};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk_cpu) begin
        if (chk_en) begin
            check("model_ic1", {2'b0, out_a}, {2'b0, model_out(0)});
            check("model_ic0", {2'b0, out_b}, {2'b0, model_out(1)});
        end
    end

    task automatic go_idle();
        romsel = 0; cpu_rw = 1; cpu_data_i = 8'h00;
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        @(posedge clk_cpu); #1;
        cpu_addr = a; cpu_data_i = d; romsel = 1; cpu_rw = 0;
        @(posedge clk_cpu); #1;
        go_idle();
    endtask

    task automatic serial(input logic [14:0] a, input logic [4:0] v);
        for (int k = 0; k < 5; k++) wr(a, {7'b0, v[k]});
    endtask

    initial begin
        rst_n = 0; cpu_addr = 0; ppu_addr = 0; mirrorv = 0; chr_ram = 0; prg_ram = 1;
        prg_mask = 18'h1FFFF; chr_mask = 17'h1FFFF; prgram_mask = 13'h1FFF;
        go_idle();
        repeat (2) @(posedge clk_cpu);
        #1 rst_n = 1; chk_en = 1;

        // Reset state: $C000 maps to bank F folded to 7 by the mask.
        cpu_addr = 15'h4000; romsel = 1; #1;
        check("rst_prg_addr", 64'(prg_addr_a), 64'h1C000);
        check("rst_mapper_reg", 64'(mapper_reg_a), 64'h0C);
        romsel = 0; prg_mask = 18'h3FFFF;

        // PRG register = 5 via $E000.
        serial(15'h6000, 5'h05);
        cpu_addr = 15'h0000; romsel = 1; #1;
        check("prg5_addr", 64'(prg_addr_a), 64'h14000);
        cpu_addr = 15'h6000; romsel = 0; #1;
        check("prgram_cs", 64'(prgram_cs_a), 64'h1);

        // CHR 4 KB mode, vertical mirroring.
        serial(15'h0000, 5'h12);
        serial(15'h2000, 5'h03);
        serial(15'h4000, 5'h09);
        check("ctrl12", 64'(mapper_reg_a), 64'h12);
        ppu_addr = 14'h0010; #1;
        check("chr_lo", 64'(chr_addr_a), 64'h03010);
        ppu_addr = 14'h1010; #1;
        check("chr_hi", 64'(chr_addr_a), 64'h09010);
        ppu_addr = 14'h2400; #1;
        check("ciram_a10", 64'(ciram_a10_a), 64'h1);
        check("chr_cs", 64'(chr_cs_a), 64'h0);

        // Partial sequence aborted by bit 7, then a clean reload.
        wr(15'h0000, 8'h01); wr(15'h0000, 8'h00); wr(15'h0000, 8'h01);
        wr(15'h0000, 8'h80);
        check("abort_ctrl", 64'(mapper_reg_a), 64'h1E);
        serial(15'h0000, 5'h0F);
        check("reload_ctrl", 64'(mapper_reg_a), 64'h0F);

        // Asynchronous reset mid-sequence.
        ppu_addr = 14'h1010;
        wr(15'h2000, 8'h01); wr(15'h2000, 8'h01);
        #1 check("pre_rst_chr", 64'(chr_addr_a), 64'h03010);
        #2 rst_n = 0;
        #1 check("async_ctrl", 64'(mapper_reg_a), 64'h0C);
        check("async_chr", 64'(chr_addr_a), 64'h01010);
        @(posedge clk_cpu); #1 rst_n = 1;
        serial(15'h2000, 5'h06);
        check("post_rst_chr", 64'(chr_addr_a), 64'h07010);

        // Back-to-back writes: dropped with IGNORE_CONSECUTIVE=1, both shifted with 0.
        @(posedge clk_cpu); #1;
        cpu_addr = 15'h0000; cpu_data_i = 8'h01; romsel = 1; cpu_rw = 0;
        @(posedge clk_cpu); #1;
        @(posedge clk_cpu); #1;
        go_idle();
        wr(15'h0000, 8'h00); wr(15'h0000, 8'h00); wr(15'h0000, 8'h01);
        check("b2b_ic1", 64'(mapper_reg_a), 64'h0C);
        check("b2b_ic0", 64'(mapper_reg_b), 64'h13);
        wr(15'h0000, 8'h00);
        check("b2b_ic1_load", 64'(mapper_reg_a), 64'h09);
        check("b2b_ic0_hold", 64'(mapper_reg_b), 64'h13);

        @(posedge clk_cpu); #1;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
